// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with start/done handshake; single-cycle ops plus 16-step shift-add MUL.
// Result and flags hold between completions; reset (rst, active-low) is asynchronous.
module alu_seq #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             z,
    output logic             cy,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    localparam int CW = $clog2(MUL_STEPS);
    localparam logic [3:0] OP_MUL = 4'b1010;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [3:0] op_q;
    logic [WIDTH-1:0] b_q, c_q, a_lo;
    logic [2*WIDTH-1:0] a_q, acc_q, acc_sum;
    logic [WIDTH:0] alu_r, res;
    logic z_q, cy_q, done_q, accept, mul_last, finish;

    assign accept   = state_q == IDLE && start;
    assign mul_last = state_q == MUL && cnt_q == CW'(MUL_STEPS - 1);
    assign finish   = state_q == EXEC || mul_last;
    assign a_lo     = a_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;

    always_comb
        state_d = accept ? (op == OP_MUL ? MUL : EXEC) : finish ? IDLE : state_q;

    always_comb begin
        busy = state_q != IDLE;
        C    = c_q;
        z    = z_q;
        cy   = cy_q;
        done = done_q;
    end

    // bit WIDTH of alu_r is the carry/borrow flag
    always_comb begin
        alu_r = '0;
        case (op_q)
            4'h0:    alu_r = {1'b0, a_lo} + {1'b0, b_q};
            4'h1:    alu_r = {1'b0, a_lo} - {1'b0, b_q};
            4'h2:    alu_r = {1'b0, a_lo & b_q};
            4'h3:    alu_r = {1'b0, a_lo | b_q};
            4'h4:    alu_r = {1'b0, a_lo ^ b_q};
            4'h5:    alu_r = {1'b0, a_lo};
            4'h6:    alu_r = {1'b0, b_q};
            4'h7:    alu_r = {1'b0, a_lo} + (WIDTH+1)'(1);
            4'h8:    alu_r = {a_lo, 1'b0};
            4'h9:    alu_r = {a_lo[0], 1'b0, a_lo[WIDTH-1:1]};
            default: alu_r = '0;
        endcase
    end

    // multiplicand shifts left and multiplier right, one partial product per step
    assign acc_sum = acc_q + (b_q[0] ? a_q : '0);
    assign res     = state_q == MUL ? {|acc_sum[2*WIDTH-1:WIDTH], acc_sum[WIDTH-1:0]} : alu_r;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            c_q    <= '0;
            z_q    <= 1'b0;
            cy_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                op_q  <= op;
                a_q   <= {{WIDTH{1'b0}}, A};
                b_q   <= B;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == MUL) begin
                a_q   <= a_q << 1;
                b_q   <= b_q >> 1;
                acc_q <= acc_sum;
                cnt_q <= cnt_q + CW'(1);
            end
            if (finish) begin
                c_q  <= res[WIDTH-1:0];
                cy_q <= res[WIDTH];
                z_q  <= res[WIDTH-1:0] == '0;
            end
        end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with hand-computed results, flags and latencies.
module tb_alu_seq;
    logic clk = 0, rst = 0, start = 0;
    logic [3:0] op = 0;
    logic [15:0] A = 0, B = 0, C;
    logic z, cy, busy, done;
    int n_chk = 0, n_pass = 0, done_cnt = 0, cyc = 0;

    alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .C(C), .z(z), .cy(cy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic go(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        start = 1; op = o; A = a; B = b;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ec, input logic ez, input logic ecy, input int elat);
        int lat;
        go(o, a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_c"}, C, ec);
        check({tag, "_z"}, z, ez);
        check({tag, "_cy"}, cy, ecy);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int d0, lat, t1;
        repeat (2) @(negedge clk);
        check("rst_c", C, 0);
        check("rst_z", z, 0);
        check("rst_cy", cy, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1;
        @(negedge clk);

        run("sub_eq", 4'h1, 16'h1234, 16'h1234, 16'h0000, 1, 0, 1);
        @(negedge clk);
        run("sub_borrow", 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1);
        @(negedge clk);

        d0 = done_cnt;
        go(4'hA, 16'h0003, 16'h0005);
        repeat (6) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst = 0;
        #1;
        check("midrst_c", C, 0);
        check("midrst_z", z, 0);
        check("midrst_cy", cy, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (20) @(negedge clk);
        check("midrst_idle", busy, 0);
        check("midrst_no_done", done_cnt - d0, 0);

        run("add_ovf", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 1);
        @(negedge clk);
        run("mul", 4'hA, 16'h0123, 16'h0045, 16'h4E6F, 0, 0, 16);
        @(negedge clk);
        run("mul_ovf", 4'hA, 16'h8000, 16'h0002, 16'h0000, 1, 1, 16);
        @(negedge clk);

        d0 = done_cnt;
        go(4'hA, 16'h0123, 16'h0045);
        repeat (4) @(negedge clk);
        go(4'h0, 16'hFFFF, 16'hFFFF);
        wait_done(lat);
        check("ign_lat", lat + 5, 16);
        check("ign_c", C, 16'h4E6F);
        check("ign_cy", cy, 0);
        check("ign_z", z, 0);
        repeat (3) @(negedge clk);
        check("ign_one_done", done_cnt - d0, 1);
        check("ign_idle", busy, 0);

        run("shl", 4'h8, 16'h8001, 16'h0000, 16'h0002, 0, 1, 1);
        t1 = cyc;
        run("shr_b2b", 4'h9, 16'h0003, 16'h0000, 16'h0001, 0, 1, 1);
        check("b2b_gap", cyc - t1, 2);
        @(negedge clk);
        run("rsv", 4'hF, 16'h1234, 16'h5678, 16'h0000, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
